// File: rtl/cameralink_pkg.sv
// Shared constants for the Camera Link test-pattern source: default timing,
// pixel width and the LFSR seed/taps used when CAMLINK_LFSR_EN is defined.
package cameralink_pkg;

  localparam int DEF_SIZEX  = 640;
  localparam int DEF_SIZEY  = 512;
  localparam int DEF_HBLANK = 32;
  localparam int DEF_VBLANK = 4;

  localparam int PIX_W = 16;
  localparam int CNT_W = 32;

  localparam logic [PIX_W-1:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 taps bits 0,2,3,5
  localparam logic [PIX_W-1:0] LFSR_TAPS = 16'h002D;

  function automatic logic [PIX_W-1:0] lfsr_step(input logic [PIX_W-1:0] s);
    logic fb;
    fb = ^(s & LFSR_TAPS);
    return {fb, s[PIX_W-1:1]};
  endfunction

endpackage

// File: rtl/cameralink_if.sv
// Camera Link video bus: pixel data, frame/line valids and pixel/line indices.
interface cameralink_if;
  import cameralink_pkg::*;

  logic [PIX_W-1:0] AB_DATA;
  logic             FVAL;
  logic             LVAL;
  logic [CNT_W-1:0] x_cnt;
  logic [CNT_W-1:0] y_cnt;

  modport master (output AB_DATA, FVAL, LVAL, x_cnt, y_cnt);
  modport slave  (input  AB_DATA, FVAL, LVAL, x_cnt, y_cnt);

endinterface

// File: rtl/cl_pattern_gen.sv
// Registered pixel generator: ramp {y,x} by default, or a frame-restarted
// 16-bit LFSR when CAMLINK_LFSR_EN is defined.
module cl_pattern_gen
  import cameralink_pkg::*;
(
  input  logic             CLK,
  input  logic             Reset,
  input  logic             line_valid,
  input  logic             frame_start,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  output logic [PIX_W-1:0] pixel
);

  logic [PIX_W-1:0] pixel_q, pixel_d;

`ifdef CAMLINK_LFSR_EN
  logic [PIX_W-1:0] lfsr_q, lfsr_d, lfsr_cur;
  logic [15:0]      unused_xy;

  assign unused_xy = {y, x};

  // The frame's first pixel uses the seed directly, so the reload costs no cycle
  always_comb begin
    lfsr_cur = frame_start ? LFSR_SEED : lfsr_q;
    lfsr_d   = line_valid ? lfsr_step(lfsr_cur) : lfsr_cur;
    pixel_d  = line_valid ? lfsr_cur : '0;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;

  always_comb begin
    pixel_d = line_valid ? {y, x} : '0;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!Reset) pixel_q <= '0;
    else        pixel_q <= pixel_d;
  end

  assign pixel = pixel_q;

endmodule

// File: rtl/cameralink_source.sv
// Camera Link video source: free-running line/frame counters with registered
// FVAL/LVAL/x_cnt/y_cnt; pixel pattern (ramp or CAMLINK_LFSR_EN) in cl_pattern_gen.
module cameralink_source
  import cameralink_pkg::*;
#(
  parameter int SIZEX  = DEF_SIZEX,
  parameter int SIZEY  = DEF_SIZEY,
  parameter int HBLANK = DEF_HBLANK,
  parameter int VBLANK = DEF_VBLANK
) (
  input  logic         CLK,
  input  logic         Reset,
  cameralink_if.master cl
);

  localparam int LINE_LEN    = SIZEX + HBLANK;
  localparam int FRAME_LINES = SIZEY + VBLANK;
  localparam int HC_W        = $clog2(LINE_LEN);
  localparam int VC_W        = $clog2(FRAME_LINES);

  localparam logic [HC_W-1:0] HC_LAST  = HC_W'(LINE_LEN - 1);
  localparam logic [VC_W-1:0] VC_LAST  = VC_W'(FRAME_LINES - 1);
  localparam logic [HC_W-1:0] SIZEX_HC = HC_W'(SIZEX);
  localparam logic [VC_W-1:0] SIZEY_VC = VC_W'(SIZEY);

  logic [HC_W-1:0]  hc_q, hc_d;
  logic [VC_W-1:0]  vc_q, vc_d;
  logic             fval_q, fval_d;
  logic             lval_q, lval_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             frame_start;

  // Outputs decode the counter state held before the edge, so the first
  // edge out of reset presents pixel (0,0)
  always_comb begin
    hc_d = hc_q + HC_W'(1);
    vc_d = vc_q;
    if (hc_q == HC_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == VC_LAST) ? '0 : vc_q + VC_W'(1);
    end
    fval_d      = (vc_q < SIZEY_VC);
    lval_d      = fval_d && (hc_q < SIZEX_HC);
    x_d         = lval_d ? CNT_W'(hc_q) : '0;
    y_d         = fval_d ? CNT_W'(vc_q) : '0;
    frame_start = (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      hc_q   <= '0;
      vc_q   <= '0;
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      fval_q <= fval_d;
      lval_q <= lval_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  cl_pattern_gen u_pattern (
    .CLK         (CLK),
    .Reset       (Reset),
    .line_valid  (lval_d),
    .frame_start (frame_start),
    .x           (x_d[7:0]),
    .y           (y_d[7:0]),
    .pixel       (cl.AB_DATA)
  );

  assign cl.FVAL  = fval_q;
  assign cl.LVAL  = lval_q;
  assign cl.x_cnt = x_q;
  assign cl.y_cnt = y_q;

endmodule

// File: tb/tb_cameralink_source.sv
// Directed bench for cameralink_source: small-geometry timing/pattern/reset
// checks, default-geometry line checks, and a tall geometry for 512-line frames.
module tb_cameralink_source;

  logic CLK     = 1'b0;
  logic rst_s   = 1'b0;
  logic rst_big = 1'b0;

  int tests    = 0;
  int failures = 0;
  int cur_t    = 0;

  always #5 CLK = ~CLK;

  cameralink_if s_if ();
  cameralink_if d_if ();
  cameralink_if t_if ();

  cameralink_source #(.SIZEX(4), .SIZEY(3), .HBLANK(2), .VBLANK(2)) u_small (
    .CLK(CLK), .Reset(rst_s), .cl(s_if.master));

  cameralink_source u_default (
    .CLK(CLK), .Reset(rst_big), .cl(d_if.master));

  cameralink_source #(.SIZEX(8), .SIZEY(512), .HBLANK(1), .VBLANK(4)) u_tall (
    .CLK(CLK), .Reset(rst_big), .cl(t_if.master));

  // Stats gathered over the first 98 cycles of the small source
  int          fval_low_frame0 = 0;
  int          fval_rises[$];
  logic [5:0]  lval_line0 = '0;
  logic        prev_fval  = 1'b0;

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cur_t, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_lfsr(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Runs n cycles of the small source from pixel (0,0), comparing every output
  task automatic run_small(input int n, input bit collect);
    int          hc, vc;
    logic        efval, elval;
    logic [31:0] ex, ey, epix;
    logic [15:0] lfsr_m;
    lfsr_m = 16'hACE1;
    for (int t = 0; t < n; t++) begin
      @(posedge CLK);
      @(negedge CLK);
      cur_t = t;
      hc    = t % 6;
      vc    = (t / 6) % 5;
      efval = (vc < 3);
      elval = efval && (hc < 4);
      ex    = elval ? hc : 0;
      ey    = efval ? vc : 0;
`ifdef CAMLINK_LFSR_EN
      if (hc == 0 && vc == 0) lfsr_m = 16'hACE1;
      epix = elval ? {16'h0, lfsr_m} : 32'h0;
      if (elval) lfsr_m = model_lfsr(lfsr_m);
`else
      epix = elval ? {16'h0, ey[7:0], ex[7:0]} : 32'h0;
`endif
      check_output("s_fval",  s_if.FVAL,    efval);
      check_output("s_lval",  s_if.LVAL,    elval);
      check_output("s_x_cnt", s_if.x_cnt,   ex);
      check_output("s_y_cnt", s_if.y_cnt,   ey);
      check_output("s_data",  s_if.AB_DATA, epix);
      if (collect) begin
        if (t < 30 && !s_if.FVAL) fval_low_frame0++;
        if (t > 0 && s_if.FVAL && !prev_fval) fval_rises.push_back(t);
        if (t < 6) lval_line0[5-t] = s_if.LVAL;
        prev_fval = s_if.FVAL;
`ifdef CAMLINK_LFSR_EN
        if (t == 0)  check_output("lfsr_px00",    s_if.AB_DATA, 32'hACE1);
        if (t == 1)  check_output("lfsr_px10",    s_if.AB_DATA, 32'h5670);
        if (t == 30) check_output("lfsr_frame2",  s_if.AB_DATA, 32'hACE1);
`else
        if (t == 0)  check_output("ramp_px00",    s_if.AB_DATA, 32'h0000);
        if (t == 15) check_output("ramp_l2p3",    s_if.AB_DATA, 32'h0203);
        if (t == 16) check_output("blank_data",   s_if.AB_DATA, 32'h0000);
        if (t == 16) check_output("blank_y_hold", s_if.y_cnt,   32'd2);
`endif
      end
    end
  endtask

  initial begin
    int d_lval_l0, d_lval_l1, d_max_x;
    int t_lines, t_fval_cyc, t_max_y;
    logic t_prev_lval;

    // Small source held in reset for 3 clocks
    @(negedge CLK);
    rst_s = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    cur_t = -1;
    check_output("rst_fval",  s_if.FVAL,    0);
    check_output("rst_lval",  s_if.LVAL,    0);
    check_output("rst_x_cnt", s_if.x_cnt,   0);
    check_output("rst_y_cnt", s_if.y_cnt,   0);
    check_output("rst_data",  s_if.AB_DATA, 0);

    // Release, then run 3 frames plus 8 cycles (up to line 1 pixel 1)
    rst_s = 1'b1;
    run_small(98, 1'b1);
    check_output("lval_line0", lval_line0, 6'b111100);
    check_output("fval_low_clocks", fval_low_frame0, 12);
    check_output("fval_rise_count", fval_rises.size(), 3);
    if (fval_rises.size() >= 3) begin
      check_output("frame1_start", fval_rises[0], 30);
      check_output("frame2_start", fval_rises[1], 60);
      check_output("frame3_start", fval_rises[2], 90);
    end

    // One-clock reset where line 1 pixel 2 would have appeared
    rst_s = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    cur_t = -2;
    check_output("mid_rst_fval",  s_if.FVAL,    0);
    check_output("mid_rst_lval",  s_if.LVAL,    0);
    check_output("mid_rst_x_cnt", s_if.x_cnt,   0);
    check_output("mid_rst_y_cnt", s_if.y_cnt,   0);
    check_output("mid_rst_data",  s_if.AB_DATA, 0);
    rst_s = 1'b1;
    run_small(8, 1'b0);

    // Default and tall geometries released together
    rst_big     = 1'b1;
    d_lval_l0   = 0;
    d_lval_l1   = 0;
    d_max_x     = 0;
    t_lines     = 0;
    t_fval_cyc  = 0;
    t_max_y     = 0;
    t_prev_lval = 1'b0;
    for (int t = 0; t < 4644; t++) begin
      @(posedge CLK);
      @(negedge CLK);
      cur_t = t;
      if (t == 0) begin
        check_output("def_first_fval", d_if.FVAL, 1);
        check_output("def_first_lval", d_if.LVAL, 1);
        check_output("tall_first_fval", t_if.FVAL, 1);
      end
      if (t == 672) check_output("def_line1_y", d_if.y_cnt, 1);
      if (t < 672 && d_if.LVAL) d_lval_l0++;
      if (t >= 672 && t < 1344 && d_if.LVAL) d_lval_l1++;
      if (t < 1344 && d_if.LVAL && int'(d_if.x_cnt) > d_max_x) d_max_x = int'(d_if.x_cnt);
      if (t_if.LVAL && !t_prev_lval) t_lines++;
      t_prev_lval = t_if.LVAL;
      if (t_if.FVAL) t_fval_cyc++;
      if (t_if.FVAL && int'(t_if.y_cnt) > t_max_y) t_max_y = int'(t_if.y_cnt);
    end
    cur_t = -3;
    check_output("def_lval_line0", d_lval_l0, 640);
    check_output("def_lval_line1", d_lval_l1, 640);
    check_output("def_max_x",      d_max_x,   639);
    check_output("tall_lines",     t_lines,   512);
    check_output("tall_fval_cyc",  t_fval_cyc, 4608);
    check_output("tall_max_y",     t_max_y,   511);
    @(negedge CLK);
    check_output("tall_next_frame_fval", t_if.FVAL, 1);
    check_output("tall_next_frame_y",    t_if.y_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
